// File: rtl/serial_feeder.sv
// Parallel-to-serial frame feeder: accepts a WIDTH-bit word, shifts it out one bit per
// cycle with x_valid, pulses frame_done, then holds off GAP idle cycles before the next word.
module serial_feeder #(
  parameter int WIDTH     = 8,
  parameter int GAP       = 1,
  parameter int LSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             frame_done
);

  localparam int CW = $clog2(WIDTH);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LOAD = (GAP > 0) ? GW'(GAP - 1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  state_t            state, state_n;
  logic [WIDTH-1:0]  sreg, sreg_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [GW-1:0]     gcnt, gcnt_n;
  logic              x_n, x_valid_n, busy_n, frame_done_n;
  logic              take;

  assign din_ready = (state == S_IDLE) && reset;
  assign take      = din_valid && din_ready;

  // sreg always holds the bits still to be shown, next bit at the output end,
  // so the first bit can be registered onto x directly from din at the transfer edge.
  always_comb begin
    state_n      = state;
    sreg_n       = sreg;
    cnt_n        = cnt;
    gcnt_n       = gcnt;
    x_n          = 1'b0;
    x_valid_n    = 1'b0;
    frame_done_n = 1'b0;
    case (state)
      S_IDLE: begin
        if (take) begin
          state_n   = S_SHIFT;
          cnt_n     = CNT_LOAD;
          x_valid_n = 1'b1;
          if (LSB_FIRST != 0) begin
            x_n    = din[0];
            sreg_n = din >> 1;
          end else begin
            x_n    = din[WIDTH-1];
            sreg_n = din << 1;
          end
        end
      end
      S_SHIFT: begin
        if (cnt == '0) begin
          frame_done_n = 1'b1;
          if (GAP > 0) begin
            state_n = S_GAP;
            gcnt_n  = GAP_LOAD;
          end else begin
            state_n = S_IDLE;
          end
        end else begin
          cnt_n     = cnt - 1'b1;
          x_valid_n = 1'b1;
          if (LSB_FIRST != 0) begin
            x_n    = sreg[0];
            sreg_n = sreg >> 1;
          end else begin
            x_n    = sreg[WIDTH-1];
            sreg_n = sreg << 1;
          end
        end
      end
      S_GAP: begin
        if (gcnt == '0) state_n = S_IDLE;
        else            gcnt_n  = gcnt - 1'b1;
      end
      default: state_n = S_IDLE;
    endcase
    busy_n = (state_n != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      sreg       <= '0;
      cnt        <= '0;
      gcnt       <= '0;
      x          <= 1'b0;
      x_valid    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      sreg       <= sreg_n;
      cnt        <= cnt_n;
      gcnt       <= gcnt_n;
      x          <= x_n;
      x_valid    <= x_valid_n;
      busy       <= busy_n;
      frame_done <= frame_done_n;
    end
  end

endmodule

// File: doc/serial_feeder.md
SERIAL_FEEDER -- requirements
Module: serial_feeder

Interface
REQ-001 Parameter WIDTH, default 8: frame length in bits; legal range 2..32.
REQ-002 Parameter GAP, default 1: idle cycles forced between frames; legal range 0..15.
REQ-003 Parameter LSB_FIRST, default 0: 0 sends MSB first, 1 sends LSB first.
REQ-004 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-005 Port reset, input, 1: reset is synchronous and active-low; reset=0 sampled at a rising clk edge resets the block.
REQ-006 Port din, input, WIDTH: parallel word to serialize.
REQ-007 Port din_valid, input, 1: din holds a word offered for transfer.
REQ-008 Port din_ready, output, 1: block can accept a word this cycle.
REQ-009 Port x, output, 1: serial bit stream for the downstream sequence stage.
REQ-010 Port x_valid, output, 1: x carries a frame bit this cycle.
REQ-011 Port busy, output, 1: frame in progress (SHIFT or GAP state).
REQ-012 Port frame_done, output, 1: one-cycle pulse after the last bit of a frame.

Function
REQ-013 FSM states SHALL be IDLE, SHIFT and GAP; the encoding is free.
REQ-014 din_ready SHALL equal (state==IDLE) AND reset; it is combinational and all other outputs are registered.
REQ-015 Transfer SHALL occur on an edge where din_valid=1 and din_ready=1: capture din into the shift register, load bit counter with WIDTH-1, go IDLE->SHIFT.
REQ-016 din SHALL be ignored on every edge where no transfer occurs; din_valid held high outside IDLE causes no capture.
REQ-017 Latency: the first frame bit SHALL appear on x with x_valid=1 in the cycle immediately after the transfer edge.
REQ-018 In SHIFT, x SHALL present one bit per cycle (MSB->LSB if LSB_FIRST=0, LSB->MSB if 1), and the counter SHALL decrement each edge.
REQ-019 On the edge where the counter is 0 (last bit shown), the FSM SHALL leave SHIFT: to GAP with gap counter GAP-1 if GAP>0, else to IDLE.
REQ-020 frame_done SHALL be 1 for exactly the one cycle following the last-bit cycle and 0 otherwise.
REQ-021 In GAP and IDLE, x=0 and x_valid=0; GAP SHALL last exactly GAP cycles, then go to IDLE.
REQ-022 With GAP=0, the minimum frame-to-frame period SHALL be WIDTH+1 cycles, because one IDLE cycle is always required for din_ready.
REQ-023 busy SHALL be 1 exactly while the state is SHIFT or GAP.
REQ-024 A frame of WIDTH bits SHALL produce exactly WIDTH consecutive x_valid=1 cycles, never split or extended.
REQ-025 Counters SHALL NOT wrap; all counter widths SHALL be sized to hold WIDTH-1 and GAP-1.

Reset
REQ-026 On a reset edge the block SHALL go to IDLE, clear the shift register and counters, and set x=0, x_valid=0, busy=0 and frame_done=0.
REQ-027 While reset=0, din_ready SHALL be 0 and no transfer SHALL occur even if din_valid=1.
REQ-028 Reset during SHIFT or GAP SHALL abandon the frame with no frame_done pulse; the next transfer restarts from bit 0.
REQ-029 After reset is released, din_ready SHALL be 1 in the first cycle (IDLE).

Verification
REQ-030 Basic frame (WIDTH=8, GAP=1, LSB_FIRST=0): transfer A5h -> x = 1,0,1,0,0,1,0,1 on 8 consecutive cycles with x_valid=1, frame_done=1 on the 9th cycle, din_ready=1 again on the 10th cycle.
REQ-031 LSB-first frame (LSB_FIRST=1): transfer 01h -> x = 1,0,0,0,0,0,0,0.
REQ-032 Back-to-back frames (GAP=0): din_valid held high with 3Ch then C3h -> 00111100 then 11000011, with exactly one x_valid=0 cycle between the frames.
REQ-033 Ignore while busy: din changed to FFh mid-frame with din_valid=1 -> current frame bits unaltered and FFh transferred only in the next IDLE.
REQ-034 Reset mid-frame: reset=0 at bit 4 of A5h -> next cycle x_valid=0, busy=0, no frame_done; a later 0Fh sends 00001111.
REQ-035 Downstream stimulus: transfer 55h -> x = 0,1,0,1,0,1,0,1, matching the alternating x pattern the downstream sequence stage is exercised with.
